// File: rtl/mem_arbiter_ctrl_if.sv
// mem_arbiter_ctrl_if
//   Bundles the per-channel request/response lines and the byte-serial
//   RAM/IO bus of mem_arbiter_ctrl.
//   slave  : controller side (serves requests, drives the RAM/IO pins)
//   master : environment side (requesters plus the RAM/IO model)
//   Signals: mem_din/mem_dout/mem_a/mem_wr (memory bus), req_valid/req_wr/
//   req_signed/req_len/req_addr/req_wdata (per-channel request, packed by
//   channel), rsp_rdata (shared load data), rsp_done (one-hot), busy.
interface mem_arbiter_ctrl_if #(
  parameter int NUM_CH    = 2,
  parameter int MAX_BYTES = 8,
  parameter int LEN_W     = $clog2(MAX_BYTES)
);
  logic [7:0]                         mem_din;
  logic [7:0]                         mem_dout;
  logic [31:0]                        mem_a;
  logic                               mem_wr;
  logic [NUM_CH-1:0]                  req_valid;
  logic [NUM_CH-1:0]                  req_wr;
  logic [NUM_CH-1:0]                  req_signed;
  logic [NUM_CH-1:0][LEN_W-1:0]       req_len;
  logic [NUM_CH-1:0][31:0]            req_addr;
  logic [NUM_CH-1:0][8*MAX_BYTES-1:0] req_wdata;
  logic [8*MAX_BYTES-1:0]             rsp_rdata;
  logic [NUM_CH-1:0]                  rsp_done;
  logic                               busy;

  modport slave (
    input  mem_din, req_valid, req_wr, req_signed, req_len, req_addr, req_wdata,
    output mem_dout, mem_a, mem_wr, rsp_rdata, rsp_done, busy
  );

  modport master (
    output mem_din, req_valid, req_wr, req_signed, req_len, req_addr, req_wdata,
    input  mem_dout, mem_a, mem_wr, rsp_rdata, rsp_done, busy
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl
//   Byte-serial memory controller: arbitrates NUM_CH requesters onto one
//   8-bit RAM/IO bus. Bursts of 1..MAX_BYTES bytes, sign/zero-extended loads,
//   per-channel read abort on clear_signal, store stalling on a full IO buffer
//   (addr[17:16] == 2'b11), global pause via rdy_in.
// Ports:
//   clk_in, rst_n_in (synchronous, active low), rdy_in (pause when low),
//   io_buffer_full, clear_signal, bus (mem_arbiter_ctrl_if.slave).
// Build option:
//   MEM_CTRL_FIXED_PRIO_EN defined   -> fixed priority, lowest index wins.
//   MEM_CTRL_FIXED_PRIO_EN undefined -> round-robin starting at a pointer.
module mem_arbiter_ctrl #(
  parameter int                NUM_CH     = 2,
  parameter int                MAX_BYTES  = 8,
  parameter int                LEN_W      = $clog2(MAX_BYTES),
  parameter logic [NUM_CH-1:0] CLEAR_MASK = {NUM_CH{1'b1}}
) (
  input logic               clk_in,
  input logic               rst_n_in,
  input logic               rdy_in,
  input logic               io_buffer_full,
  input logic               clear_signal,
  mem_arbiter_ctrl_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, WSTALL} state_t;

  state_t                    state;
  logic [CH_W-1:0]           ch;
  logic [31:0]               addr;
  logic [LEN_W-1:0]          len;
  logic                      sgn;
  logic [MAX_BYTES-1:0][7:0] wbuf;
  logic [MAX_BYTES-1:0][7:0] rbuf;
  logic [LEN_W-1:0]          cnt;     // read: bytes captured; write: next byte to issue
  logic                      bubble;  // read address was dropped by a pause

`ifndef MEM_CTRL_FIXED_PRIO_EN
  logic [CH_W-1:0]           ptr;
  logic [CH_W-1:0]           rr_idx;
`endif

  // ---------------- arbitration ----------------
  logic [NUM_CH-1:0] elig;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt_ch;

  assign elig = bus.req_valid & ~bus.rsp_done & ~({NUM_CH{clear_signal}} & CLEAR_MASK);

  // Scan from the far end so the nearest eligible candidate is written last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
`ifdef MEM_CTRL_FIXED_PRIO_EN
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[CH_W'(i)]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(i);
      end
    end
`else
    rr_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      rr_idx = CH_W'((int'(ptr) + i) % NUM_CH);
      if (elig[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = rr_idx;
      end
    end
`endif
  end

  // ---------------- store issue path ----------------
  // A store's first byte goes out on the grant edge, so in IDLE the issue
  // path looks at the granted request directly instead of the latched copy.
  logic [CH_W-1:0]           cur_ch;
  logic [31:0]               cur_addr;
  logic [LEN_W-1:0]          cur_len;
  logic [MAX_BYTES-1:0][7:0] cur_wdata;
  logic [LEN_W-1:0]          wr_idx;
  logic                      do_issue;
  logic                      io_stall;

  always_comb begin
    if (state == IDLE) begin
      cur_ch    = gnt_ch;
      cur_addr  = bus.req_addr[gnt_ch];
      cur_len   = bus.req_len[gnt_ch];
      cur_wdata = bus.req_wdata[gnt_ch];
      wr_idx    = '0;
      do_issue  = gnt_vld && bus.req_wr[gnt_ch];
    end else begin
      cur_ch    = ch;
      cur_addr  = addr;
      cur_len   = len;
      cur_wdata = wbuf;
      wr_idx    = cnt;
      do_issue  = (state == WRITE) || (state == WSTALL);
    end
    io_stall = (cur_addr[17:16] == 2'b11) && io_buffer_full;
  end

  // ---------------- load result assembly ----------------
  // Final byte comes straight from mem_din on the completing edge; bytes
  // above it take the sign of that byte (signed) or zero.
  logic [MAX_BYTES-1:0][7:0] fill;

  always_comb begin
    fill = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < int'(len))       fill[i] = rbuf[i];
      else if (i == int'(len)) fill[i] = bus.mem_din;
      else                     fill[i] = {8{sgn & bus.mem_din[7]}};
    end
  end

  assign bus.busy = (state != IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      ch            <= '0;
      addr          <= '0;
      len           <= '0;
      sgn           <= 1'b0;
      wbuf          <= '0;
      rbuf          <= '0;
      cnt           <= '0;
      bubble        <= 1'b0;
`ifndef MEM_CTRL_FIXED_PRIO_EN
      ptr           <= '0;
`endif
      bus.mem_a     <= '0;
      bus.mem_dout  <= '0;
      bus.mem_wr    <= 1'b0;
      bus.rsp_done  <= '0;
      bus.rsp_rdata <= '0;
    end else if (!rdy_in) begin
      // Everything holds; the bus goes quiet. A read has lost its address
      // phase and must re-present it before capturing again.
      bus.mem_a    <= '0;
      bus.mem_wr   <= 1'b0;
      bus.rsp_done <= '0;
      if (state == READ) bubble <= 1'b1;
    end else begin
      bus.mem_a    <= '0;
      bus.mem_wr   <= 1'b0;
      bus.rsp_done <= '0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            ch   <= gnt_ch;
            addr <= cur_addr;
            len  <= cur_len;
            sgn  <= bus.req_signed[gnt_ch];
            wbuf <= cur_wdata;
`ifndef MEM_CTRL_FIXED_PRIO_EN
            ptr  <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
`endif
            if (!bus.req_wr[gnt_ch]) begin
              state     <= READ;
              cnt       <= '0;
              bubble    <= 1'b0;
              bus.mem_a <= cur_addr;
            end
          end
        end
        READ: begin
          if (clear_signal && CLEAR_MASK[ch]) begin
            state <= IDLE;
          end else if (bubble) begin
            bubble    <= 1'b0;
            bus.mem_a <= addr + 32'(cnt);
          end else begin
            rbuf[cnt] <= bus.mem_din;
            if (cnt == len) begin
              bus.rsp_rdata    <= fill;
              bus.rsp_done[ch] <= 1'b1;
              state            <= IDLE;
            end else begin
              cnt       <= cnt + 1'b1;
              bus.mem_a <= addr + 32'(cnt) + 32'd1;
            end
          end
        end
        default: ;
      endcase

      // Store byte issue, shared by the grant edge, WRITE and WSTALL.
      if (do_issue) begin
        if (io_stall) begin
          state <= WSTALL;
          cnt   <= wr_idx;
        end else begin
          bus.mem_wr   <= 1'b1;
          bus.mem_a    <= cur_addr + 32'(wr_idx);
          bus.mem_dout <= cur_wdata[wr_idx];
          if (wr_idx == cur_len) begin
            bus.rsp_done[cur_ch] <= 1'b1;
            state                <= IDLE;
          end else begin
            cnt   <= wr_idx + 1'b1;
            state <= WRITE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: directed vectors with hand-computed expectations for
// mem_arbiter_ctrl (NUM_CH=2, MAX_BYTES=8). Read data comes from a small RAM
// indexed by mem_a[7:0]; every bus write is logged as {addr, data}.
module tb_mem_arbiter_ctrl;
  logic clk = 1'b0;
  logic rst_n, rdy, io_full, clr;
  logic [7:0] ram [256];
  logic [39:0] wlog [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter_ctrl_if #(.NUM_CH(2), .MAX_BYTES(8)) bus ();

  mem_arbiter_ctrl #(.NUM_CH(2), .MAX_BYTES(8)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy),
    .io_buffer_full (io_full),
    .clear_signal   (clr),
    .bus            (bus)
  );

  // Address presented in one cycle is answered by the next edge.
  assign bus.mem_din = ram[bus.mem_a[7:0]];

  always @(posedge clk) if (bus.mem_wr) wlog.push_back({bus.mem_a, bus.mem_dout});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_set(input int c, input logic w, input logic s, input int l,
                         input logic [31:0] a, input logic [63:0] d);
    bus.req_wr[c]     = w;
    bus.req_signed[c] = s;
    bus.req_len[c]    = 3'(l);
    bus.req_addr[c]   = a;
    bus.req_wdata[c]  = d;
    bus.req_valid[c]  = 1'b1;
  endtask

  // Load of l+1 bytes: done is expected on the (l+1)-th edge after grant.
  task automatic do_read(input int c, input logic [31:0] a, input int l, input logic s,
                         input logic [63:0] exp, input string tag);
    int k;
    req_set(c, 1'b0, s, l, a, 64'h0);
    tick();
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    chk({tag, "_a0"}, 64'(bus.mem_a), 64'(a));
    k = 0;
    while (bus.rsp_done == 2'b00 && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(l + 1));
    chk({tag, "_done"}, 64'(bus.rsp_done), 64'(1 << c));
    chk({tag, "_data"}, bus.rsp_rdata, exp);
    bus.req_valid[c] = 1'b0;
    tick();
    chk({tag, "_pulse"}, 64'(bus.rsp_done), 64'd0);
  endtask

  initial begin
    int base, k;
    logic [39:0] e;
    logic [7:0] init [8];
    init = '{8'h11, 8'h22, 8'h33, 8'h84, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    for (int i = 0; i < 8; i++) ram[i] = init[i];
    ram[255] = 8'h9A;
    rst_n = 1'b0; rdy = 1'b1; io_full = 1'b0; clr = 1'b0;
    bus.req_valid = '0; bus.req_wr = '0; bus.req_signed = '0;
    bus.req_len = '0; bus.req_addr = '0; bus.req_wdata = '0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_mem_a", 64'(bus.mem_a), 64'd0);
    chk("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_dout", 64'(bus.mem_dout), 64'd0);
    chk("rst_done", 64'(bus.rsp_done), 64'd0);
    chk("rst_rdata", bus.rsp_rdata, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // ---- loads: sign/zero extension, lengths 1..8, address wrap ----
    do_read(1, 32'h100, 3, 1'b1, 64'hFFFFFFFF_84332211, "ld_s4");
    do_read(1, 32'h102, 1, 1'b0, 64'h00000000_00008433, "ld_u2");
    do_read(0, 32'h103, 0, 1'b1, 64'hFFFFFFFF_FFFFFF84, "ld_s1");
    do_read(0, 32'h100, 7, 1'b1, 64'h88776655_84332211, "ld_s8");
    do_read(1, 32'hFFFFFFFF, 1, 1'b0, 64'h00000000_0000119A, "ld_wrap");

    // ---- IO-buffer-full stall on a 1-byte store ----
    base = wlog.size();
    io_full = 1'b1;
    req_set(0, 1'b1, 1'b0, 0, 32'h0003_0000, 64'h41);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("io_stall_wr", 64'(bus.mem_wr), 64'd0);
      chk("io_stall_done", 64'(bus.rsp_done), 64'd0);
    end
    chk("io_busy", 64'(bus.busy), 64'd1);
    io_full = 1'b0;
    tick();
    chk("io_wr", 64'(bus.mem_wr), 64'd1);
    chk("io_a", 64'(bus.mem_a), 64'h30000);
    chk("io_dout", 64'(bus.mem_dout), 64'h41);
    chk("io_done", 64'(bus.rsp_done), 64'd1);
    bus.req_valid[0] = 1'b0;
    tick();
    chk("io_idle", 64'(bus.busy), 64'd0);
    chk("io_nwr", 64'(wlog.size() - base), 64'd1);
    chk("io_log", 64'(wlog[base]), 64'({32'h30000, 8'h41}));

    // ---- arbitration: both channels holding requests ----
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_set(0, 1'b1, 1'b0, 0, 32'h40, 64'hAA);
    req_set(1, 1'b1, 1'b0, 0, 32'h50, 64'hBB);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arb_alt", 64'(bus.rsp_done), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    bus.req_valid = '0;
    tick(); tick();
    // Last grant was ch0, so both arriving together now goes to ch1.
    bus.req_valid = 2'b11;
    tick();
`ifdef MEM_CTRL_FIXED_PRIO_EN
    chk("arb_tie_done", 64'(bus.rsp_done), 64'd1);
    chk("arb_tie_a", 64'(bus.mem_a), 64'h40);
`else
    chk("arb_tie_done", 64'(bus.rsp_done), 64'd2);
    chk("arb_tie_a", 64'(bus.mem_a), 64'h50);
`endif
    bus.req_valid = '0;
    tick();

    // ---- clear_signal: gates grants, aborts reads ----
    clr = 1'b1;
    req_set(0, 1'b0, 1'b0, 7, 32'h100, 64'h0);
    tick();
    chk("clr_gate", 64'(bus.busy), 64'd0);
    clr = 1'b0;
    tick();
    chk("clr_gnt", 64'(bus.busy), 64'd1);
    tick(); tick(); tick();
    clr = 1'b1;
    tick();
    chk("clr_abort_busy", 64'(bus.busy), 64'd0);
    chk("clr_abort_done", 64'(bus.rsp_done), 64'd0);
    chk("clr_abort_rdata", bus.rsp_rdata, 64'd0);
    bus.req_valid[0] = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_nodone", 64'(bus.rsp_done), 64'd0);
    end

    // A store keeps going through a clear pulse.
    base = wlog.size();
    req_set(1, 1'b1, 1'b0, 3, 32'h60, 64'h0D0C0B0A);
    tick(); tick();
    clr = 1'b1;
    tick();
    chk("clr_st_busy", 64'(bus.busy), 64'd1);
    chk("clr_st_wr", 64'(bus.mem_wr), 64'd1);
    clr = 1'b0;
    tick();
    chk("clr_st_done", 64'(bus.rsp_done), 64'd2);
    bus.req_valid[1] = 1'b0;
    tick();
    chk("clr_st_nwr", 64'(wlog.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      e = {32'h60 + 32'(i), 8'(8'h0A + i)};
      chk("clr_st_log", 64'(wlog[base + i]), 64'(e));
    end

    // ---- rdy_in pause during byte 2 of a 4-byte store ----
    base = wlog.size();
    req_set(0, 1'b1, 1'b0, 3, 32'h70, 64'h44332211);
    tick();
    chk("pz_a0", 64'(bus.mem_a), 64'h70);
    tick();
    chk("pz_a1", 64'(bus.mem_a), 64'h71);
    rdy = 1'b0;
    tick();
    chk("pz_wr0", 64'(bus.mem_wr), 64'd0);
    chk("pz_a_q", 64'(bus.mem_a), 64'd0);
    tick();
    chk("pz_wr1", 64'(bus.mem_wr), 64'd0);
    rdy = 1'b1;
    tick();
    chk("pz_re_wr", 64'(bus.mem_wr), 64'd1);
    chk("pz_re_a", 64'(bus.mem_a), 64'h72);
    chk("pz_re_d", 64'(bus.mem_dout), 64'h33);
    tick();
    chk("pz_last_a", 64'(bus.mem_a), 64'h73);
    chk("pz_done", 64'(bus.rsp_done), 64'd1);
    bus.req_valid[0] = 1'b0;
    tick();
    chk("pz_nwr", 64'(wlog.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      e = {32'h70 + 32'(i), 8'(8'h11 * (i + 1))};
      chk("pz_log", 64'(wlog[base + i]), 64'(e));
    end

    // ---- rdy_in pause during a read: 2 paused edges + 1 bubble ----
    req_set(1, 1'b0, 1'b0, 1, 32'h100, 64'h0);
    tick();
    rdy = 1'b0;
    tick();
    chk("pr_a_q", 64'(bus.mem_a), 64'd0);
    tick();
    rdy = 1'b1;
    k = 0;
    while (bus.rsp_done == 2'b00 && k < 40) begin
      tick();
      k++;
    end
    chk("pr_lat", 64'(k), 64'd3);
    chk("pr_data", bus.rsp_rdata, 64'h2211);
    bus.req_valid[1] = 1'b0;
    tick();

    // ---- reset mid-read, then a normal request ----
    req_set(0, 1'b0, 1'b1, 7, 32'h100, 64'h0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("rm_a", 64'(bus.mem_a), 64'd0);
    chk("rm_wr", 64'(bus.mem_wr), 64'd0);
    chk("rm_dout", 64'(bus.mem_dout), 64'd0);
    chk("rm_busy", 64'(bus.busy), 64'd0);
    chk("rm_done", 64'(bus.rsp_done), 64'd0);
    chk("rm_rdata", bus.rsp_rdata, 64'd0);
    rst_n = 1'b1;
    do_read(0, 32'h101, 0, 1'b0, 64'h22, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
